instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage feeding decode in the five-stage pipeline. It issues in-order word fetches to a variable-latency instruction memory and buffers returned instructions with their PC+4 in a small prefetch FIFO. It presents one instruction per cycle to decode, honours the hazard unit's StallF, and redirects on branch/jump resolution. In-flight responses from the old stream are discarded.

## Interface
- ADDR_W, 32, PC / address width
- DEPTH, 4, prefetch FIFO depth and max outstanding requests (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  instruction returned (in request order)
- imem_rsp_data  in  32  returned instruction
- StallF  in  1  hazard unit: hold decode-facing outputs
- redirect_valid  in  1  taken branch/jump from decode
- redirect_pc  in  ADDR_W  target; bits [1:0] ignored (forced 00)
- instr_valid  out  1  InstrF/PCPlus4F valid
- InstrF  out  32  instruction at FIFO head
- PCPlus4F  out  ADDR_W  PC of that instruction + 4

## Operation
- State machine (2 bits): BOOT → FETCH → FLUSH → FETCH.
  - BOOT: entered on reset; lasts exactly one cycle; no requests.
  - FETCH: issues requests.
  - FLUSH: no requests; discards responses until drop_cnt = 0, then FETCH.
- Credit rule: imem_req_valid = (state==FETCH) && (outstanding + fifo_count < DEPTH). Address and valid hold stable while valid && !ready.
- Accept = imem_req_valid && imem_req_ready: outstanding += 1; fetch_pc += 4, mod 2^ADDR_W (0xFFFFFFFC → 0x0).
- Response (imem_rsp_valid, not being dropped): outstanding −= 1; push {data, pc+4} into FIFO. The pc is tracked by an issue-order PC queue or a response-PC counter. Responses never arrive with outstanding = 0.
- Pop = instr_valid && !StallF && !redirect_valid.
- Redirect (any state except BOOT):
  - FIFO cleared.
  - fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - drop_cnt ← outstanding + accept_this_cycle − rsp_this_cycle.
  - A response in the redirect cycle is discarded (old stream).
  - Next state is FLUSH if drop_cnt ≠ 0, else FETCH.
- A redirect during FLUSH reloads fetch_pc and recomputes drop_cnt the same way.
- Outputs: instr_valid = FIFO not empty. When empty, InstrF = 0 and PCPlus4F = 0.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset values: state BOOT, fetch_pc = RESET_PC, outstanding = 0, drop_cnt = 0, FIFO empty, imem_req_valid = 0, imem_req_addr = RESET_PC, instr_valid = 0, InstrF = 0, PCPlus4F = 0.
- Reset asserted mid-operation clears everything immediately. Responses arriving after reset release for pre-reset requests are out of contract.

## Timing
- First request: cycle 1 after reset deassertion (BOOT occupies cycle 0).
- Response to output: imem_rsp_valid in cycle N → instr_valid in cycle N+1 (registered FIFO, no bypass).
- With 1-cycle memory latency and no stalls: one instruction per cycle sustained, 2 cycles from request accept to instr_valid.
- Redirect in cycle N:
  - instr_valid = 0 in N+1.
  - With no outstanding requests, imem_req_addr = target in N+1.
  - Otherwise the target is issued the cycle after the last dropped response.
- StallF: instr_valid, InstrF and PCPlus4F hold their values. Fetch continues until credits are exhausted (outstanding + count = DEPTH).
- Priority, highest first: reset > redirect > StallF > normal pop.

## Test plan
- Reset release, ready = 1, 1-cycle latency, memory returns addr^0xA5A5_0000 → request addresses 0, 4, 8…; first instr_valid 3 cycles after release with InstrF = 0xA5A5_0000, PCPlus4F = 4; then one instruction per cycle.
- StallF held 8 cycles mid-stream → InstrF/PCPlus4F constant; imem_req_valid drops once the FIFO holds 4 entries and outstanding = 0; after release, 4 queued instructions drain in order, 1 per cycle.
- 3-cycle memory latency with 2 outstanding, redirect_pc = 0x0000_0103 → FIFO empties next cycle; 2 responses discarded in FLUSH; next request addr 0x0000_0100; first valid PCPlus4F = 0x104.
- Redirect in the same cycle as imem_rsp_valid, a request accept and StallF → response dropped, accepted request counted in drop_cnt, no pop; only target-stream instructions appear afterwards.
- Redirect to 0xFFFF_FFFC → PCPlus4F = 0x0000_0000 for that instruction; next request addr 0x0000_0000.
- imem_req_ready held low 5 cycles → imem_req_addr stable throughout. Reset asserted with 3 outstanding → all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: in-order word fetches to a variable-latency instruction memory,
// a small prefetch FIFO of {instr, pc+4}, StallF hold and branch/jump redirect.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              StallF,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       InstrF,
  output logic [ADDR_W-1:0] PCPlus4F
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]        state, stateNext;
  logic [ADDR_W-1:0] fetchPc, fetchPcNext;
  logic [ADDR_W-1:0] rspPc, rspPcNext;
  logic [CNT_W-1:0]  outstanding, outNext;
  logic [CNT_W-1:0]  dropCnt, dropNext;
  logic [CNT_W-1:0]  count, cntNext;
  logic [PTR_W-1:0]  wrPtr, wrPtrNext;
  logic [PTR_W-1:0]  rdPtr, rdPtrNext;
  logic              reqValidNext;
  logic              instrValidNext;
  logic [31:0]       instrNext;
  logic [ADDR_W-1:0] pc4Next;

  logic [ADDR_W-1:0] targetPc;
  logic [ADDR_W-1:0] pushPc4;
  logic              doRedirect;
  logic              accept;
  logic              flushing;
  logic              dropRsp;
  logic              push;
  logic              pop;

  logic [31:0]       instrMem [DEPTH];
  logic [ADDR_W-1:0] pcMem    [DEPTH];

  assign imem_req_addr = fetchPc;

  // Next-state, credit and FIFO bookkeeping; decode-facing outputs are precomputed here.
  always_comb begin
    stateNext      = state;
    targetPc       = redirect_pc & ~ADDR_W'(3);
    pushPc4        = rspPc + ADDR_W'(4);
    doRedirect     = redirect_valid && (state != BOOT);
    accept         = imem_req_valid && imem_req_ready;
    flushing       = (state == FLUSH) && (dropCnt != '0);
    dropRsp        = imem_rsp_valid && (doRedirect || flushing);
    push           = imem_rsp_valid && !dropRsp;
    pop            = instr_valid && !StallF && !doRedirect;
    outNext        = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    cntNext        = count + CNT_W'(push) - CNT_W'(pop);
    dropNext       = dropCnt;
    fetchPcNext    = fetchPc;
    rspPcNext      = rspPc;
    wrPtrNext      = wrPtr;
    rdPtrNext      = rdPtr;
    instrNext      = '0;
    pc4Next        = '0;

    if (flushing && imem_rsp_valid) dropNext = dropCnt - CNT_W'(1);
    if (accept) fetchPcNext = fetchPc + ADDR_W'(4);
    if (push) begin
      rspPcNext = pushPc4;
      wrPtrNext = wrPtr + PTR_W'(1);
    end
    if (pop) rdPtrNext = rdPtr + PTR_W'(1);

    // Redirect squashes the FIFO and everything still in flight from the old stream.
    if (doRedirect) begin
      cntNext     = '0;
      dropNext    = outNext;
      fetchPcNext = targetPc;
      rspPcNext   = targetPc;
      wrPtrNext   = '0;
      rdPtrNext   = '0;
    end

    case (state)
      BOOT:    stateNext = FETCH;
      FETCH:   stateNext = (doRedirect && (dropNext != '0)) ? FLUSH : FETCH;
      FLUSH:   stateNext = (dropNext != '0) ? FLUSH : FETCH;
      default: stateNext = BOOT;
    endcase

    reqValidNext   = (stateNext == FETCH) &&
                     ((SUM_W'(outNext) + SUM_W'(cntNext)) < SUM_W'(DEPTH));
    instrValidNext = (cntNext != '0);

    // Head of the FIFO next cycle, bypassing the entry written this cycle.
    if (cntNext != '0) begin
      if (push && (wrPtr == rdPtrNext)) begin
        instrNext = imem_rsp_data;
        pc4Next   = pushPc4;
      end else begin
        instrNext = instrMem[rdPtrNext];
        pc4Next   = pcMem[rdPtrNext];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= stateNext;
  end

  // Counters, pointers, PCs and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc        <= RESET_PC;
      rspPc          <= RESET_PC;
      outstanding    <= '0;
      dropCnt        <= '0;
      count          <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      InstrF         <= '0;
      PCPlus4F       <= '0;
    end else begin
      fetchPc        <= fetchPcNext;
      rspPc          <= rspPcNext;
      outstanding    <= outNext;
      dropCnt        <= dropNext;
      count          <= cntNext;
      wrPtr          <= wrPtrNext;
      rdPtr          <= rdPtrNext;
      imem_req_valid <= reqValidNext;
      instr_valid    <= instrValidNext;
      InstrF         <= instrNext;
      PCPlus4F       <= pc4Next;
    end
  end

  // FIFO storage; contents are only read while the entry is counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem_rsp_data;
      pcMem[wrPtr]    <= pushPc4;
    end
  end

endmodule
